// File: rtl/motion_diff_if.sv
// motion_diff_if: beat handshake, thresholds, per-lane diff output and frame summary of motion_diff_stream
// Ports: in_valid/in_ready/in_last/vec_new/vec_old, pix_thresh/count_thresh, out_valid/out_ready/vec_diff/lane_mask/out_last,
// frame_done/motion_count/frame_sad/motion_flag; master = beat producer and result consumer, slave = motion_diff_stream
interface motion_diff_if #(
    parameter int WIDTH     = 4,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 16,
    parameter int SAD_W     = 24
);
    logic                       in_valid, in_ready, in_last;
    logic [NUM_LANES*WIDTH-1:0] vec_new, vec_old;
    logic [WIDTH-1:0]           pix_thresh;
    logic [CNT_W-1:0]           count_thresh;
    logic                       out_valid, out_ready, out_last;
    logic [NUM_LANES*WIDTH-1:0] vec_diff;
    logic [NUM_LANES-1:0]       lane_mask;
    logic                       frame_done, motion_flag;
    logic [CNT_W-1:0]           motion_count;
    logic [SAD_W-1:0]           frame_sad;
    modport master (
        output in_valid, in_last, vec_new, vec_old, pix_thresh, count_thresh, out_ready,
        input  in_ready, out_valid, vec_diff, lane_mask, out_last, frame_done, motion_count, frame_sad, motion_flag
    );
    modport slave (
        input  in_valid, in_last, vec_new, vec_old, pix_thresh, count_thresh, out_ready,
        output in_ready, out_valid, vec_diff, lane_mask, out_last, frame_done, motion_count, frame_sad, motion_flag
    );
endinterface

// File: rtl/motion_diff_stream.sv
// motion_diff_stream: streaming lane-wise |new-old| with threshold mask and per-frame motion summary
// Ports: clk, reset_n (synchronous, active-low), bus (motion_diff_if.slave: input beat handshake, thresholds,
// registered diff beat, one-cycle frame_done with held motion_count/frame_sad/motion_flag)
// Build option: define MOTION_DIFF_SAD_EN to build the saturating frame SAD; otherwise frame_sad is tied to 0
module motion_diff_stream #(
    parameter int WIDTH     = 4,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 16,
    parameter int SAD_W     = 24
) (
    input logic          clk,
    input logic          reset_n,
    motion_diff_if.slave bus
);
    localparam int PW = $clog2(NUM_LANES + 1);
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DONE} state_t;
    state_t                     state, state_nxt;
    logic                       ov, rdy, hs, fin;
    logic [NUM_LANES*WIDTH-1:0] diff;
    logic [NUM_LANES-1:0]       mask;
    logic [PW-1:0]              pop;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [CNT_W+PW-1:0]        cnt_sum;

    assign rdy            = reset_n && state != S_DONE && (!ov || bus.out_ready);
    assign hs             = bus.in_valid && rdy;
    assign fin            = hs && bus.in_last;
    assign bus.in_ready   = rdy;
    assign bus.out_valid  = ov;
    assign bus.frame_done = state == S_DONE;

    always_comb begin
        diff = '0;
        mask = '0;
        pop  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            diff[i*WIDTH +: WIDTH] = bus.vec_new[i*WIDTH +: WIDTH] >= bus.vec_old[i*WIDTH +: WIDTH]
                ? bus.vec_new[i*WIDTH +: WIDTH] - bus.vec_old[i*WIDTH +: WIDTH]
                : bus.vec_old[i*WIDTH +: WIDTH] - bus.vec_new[i*WIDTH +: WIDTH];
            mask[i] = diff[i*WIDTH +: WIDTH] > bus.pix_thresh;
            pop     = pop + PW'(mask[i]);
        end
    end

    // widened sum: any carry into the top bits means the counter saturates
    assign cnt_sum = {{PW{1'b0}}, cnt} + (CNT_W+PW)'(pop);
    assign cnt_nxt = |cnt_sum[CNT_W+PW-1:CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    always_comb begin
        state_nxt = state == S_DONE ? S_IDLE : fin ? S_DONE : hs ? S_FRAME : state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            ov               <= 1'b0;
            bus.vec_diff     <= '0;
            bus.lane_mask    <= '0;
            bus.out_last     <= 1'b0;
            cnt              <= '0;
            bus.motion_count <= '0;
            bus.motion_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                bus.vec_diff  <= diff;
                bus.lane_mask <= mask;
                bus.out_last  <= bus.in_last;
                ov            <= 1'b1;
            end else if (bus.out_ready) begin
                ov <= 1'b0;
            end
            // the last beat publishes the summary including itself and restarts the accumulator
            if (hs)
                cnt <= bus.in_last ? '0 : cnt_nxt;
            if (fin) begin
                bus.motion_count <= cnt_nxt;
                bus.motion_flag  <= cnt_nxt >= bus.count_thresh;
            end
        end
    end

`ifdef MOTION_DIFF_SAD_EN
    localparam int SEW = WIDTH + PW;
    logic [SEW-1:0]       lane_sum;
    logic [SAD_W-1:0]     sad, sad_nxt, sad_q;
    logic [SAD_W+SEW-1:0] sad_sum;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_LANES; i++)
            lane_sum = lane_sum + SEW'(diff[i*WIDTH +: WIDTH]);
    end

    assign sad_sum       = {{SEW{1'b0}}, sad} + (SAD_W+SEW)'(lane_sum);
    assign sad_nxt       = |sad_sum[SAD_W+SEW-1:SAD_W] ? '1 : sad_sum[SAD_W-1:0];
    assign bus.frame_sad = sad_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sad   <= '0;
            sad_q <= '0;
        end else if (hs) begin
            sad <= bus.in_last ? '0 : sad_nxt;
            if (bus.in_last)
                sad_q <= sad_nxt;
        end
    end
`else
    assign bus.frame_sad = {SAD_W{1'b0}};
`endif
endmodule
